// File: rtl/ask4_pkg.sv
// rtl/ask4_pkg.sv - mode encoding, Gray symbol constants, LFSR shape and level mapping
package ask4_pkg;

  typedef enum logic [1:0] {
    MODE_PRBS    = 2'd0,
    MODE_IMPULSE = 2'd1,
    MODE_FIXED   = 2'd2,
    MODE_WORST   = 2'd3
  } mode_e;

  localparam logic [1:0] GRAY_M3 = 2'b00;
  localparam logic [1:0] GRAY_M1 = 2'b01;
  localparam logic [1:0] GRAY_P1 = 2'b11;
  localparam logic [1:0] GRAY_P3 = 2'b10;

  localparam int LFSR_W     = 15;
  localparam int LFSR_TAP_A = 14;
  localparam int LFSR_TAP_B = 13;

  // 3a is only ever used modulo 2^18; the parameter range keeps it from overflowing
  function automatic logic signed [17:0] gray_to_level(input logic [1:0] sym,
                                                       input logic signed [17:0] a);
    logic signed [17:0] a3;
    logic signed [17:0] lvl;
    a3 = (a <<< 1) + a;
    lvl = a3;
    case (sym)
      GRAY_M3: lvl = -a3;
      GRAY_M1: lvl = -a;
      GRAY_P1: lvl = a;
      default: lvl = a3;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/lfsr_prbs15.sv
// rtl/lfsr_prbs15.sv - PRBS15 Fibonacci LFSR yielding one Gray symbol (two bits) per step
module lfsr_prbs15
  import ask4_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 15'h0001
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  output logic [1:0] sym
);

  logic [LFSR_W-1:0] state;
  logic [LFSR_W-1:0] once;
  logic [LFSR_W-1:0] twice;

  always_comb begin
    once  = {state[LFSR_W-2:0], state[LFSR_TAP_A] ^ state[LFSR_TAP_B]};
    twice = {once[LFSR_W-2:0], once[LFSR_TAP_A] ^ once[LFSR_TAP_B]};
  end

  // first emitted bit is the symbol MSB
  assign sym = {state[LFSR_TAP_A], once[LFSR_TAP_A]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= SEED;
    end else if (step) begin
      state <= twice;
    end
  end

endmodule

// File: rtl/ask4_symbol_src.sv
// rtl/ask4_symbol_src.sv - 4-ASK symbol source, zero-stuffed to SPS samples per symbol
module ask4_symbol_src
  import ask4_pkg::*;
#(
  parameter int                 SPS     = 4,
  parameter logic signed [17:0] LEVEL_A = 18'sd32768,
  parameter logic [LFSR_W-1:0]  SEED    = 15'h0001
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [1:0]         sym_in,
  output logic signed [17:0] x_out,
  output logic [1:0]         sym_out,
  output logic               sym_strobe
);

  localparam int            PW      = (SPS > 2) ? $clog2(SPS) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(SPS - 1);

  logic [PW-1:0]      phase;
  logic               boundary;
  mode_e              mode_sel;
  logic               toggle_neg;
  logic               impulse_done;
  logic               toggle_next;
  logic               impulse_next;
  logic [1:0]         prbs_sym;
  logic [1:0]         sym_next;
  logic signed [17:0] x_next;

  assign boundary = enable && (phase == '0);
  assign mode_sel = mode_e'(mode);

  lfsr_prbs15 #(.SEED(SEED)) u_lfsr (
    .clk  (clk),
    .reset(reset),
    .step (boundary && (mode_sel == MODE_PRBS)),
    .sym  (prbs_sym)
  );

  // leaving a mode at a boundary clears its private state (toggle, impulse flag)
  always_comb begin
    sym_next     = prbs_sym;
    x_next       = '0;
    toggle_next  = 1'b0;
    impulse_next = 1'b0;
    case (mode_sel)
      MODE_PRBS:    sym_next = prbs_sym;
      MODE_IMPULSE: begin
        sym_next     = impulse_done ? GRAY_M3 : GRAY_P3;
        impulse_next = 1'b1;
      end
      MODE_FIXED:   sym_next = sym_in;
      default: begin
        sym_next    = toggle_neg ? GRAY_M3 : GRAY_P3;
        toggle_next = ~toggle_neg;
      end
    endcase
    if (!(mode_sel == MODE_IMPULSE && impulse_done)) begin
      x_next = gray_to_level(sym_next, LEVEL_A);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase        <= '0;
      x_out        <= '0;
      sym_out      <= GRAY_M3;
      sym_strobe   <= 1'b0;
      toggle_neg   <= 1'b0;
      impulse_done <= 1'b0;
    end else begin
      x_out      <= '0;
      sym_strobe <= 1'b0;
      if (enable) begin
        phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
      end
      if (boundary) begin
        x_out        <= x_next;
        sym_out      <= sym_next;
        sym_strobe   <= 1'b1;
        toggle_neg   <= toggle_next;
        impulse_done <= impulse_next;
      end
    end
  end

endmodule

// File: tb/tb_ask4_symbol_src.sv
// tb/tb_ask4_symbol_src.sv - scoreboard bench for ask4_symbol_src (SPS=4, a=32768, SEED=1)
module tb_ask4_symbol_src;

  localparam int SPS = 4;
  localparam int P3 = 98304;
  localparam int M3 = -98304;
  localparam int P1 = 32768;
  localparam int M1 = -32768;

  typedef struct {
    logic signed [17:0] x;
    logic [1:0]         sym;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  logic [1:0]         mode;
  logic [1:0]         sym_in;
  logic signed [17:0] x_out;
  logic [1:0]         sym_out;
  logic               sym_strobe;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   last_sc = -1;
  int   n;

  ask4_symbol_src #(.SPS(SPS), .LEVEL_A(18'sd32768), .SEED(15'h0001)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .mode      (mode),
    .sym_in    (sym_in),
    .x_out     (x_out),
    .sym_out   (sym_out),
    .sym_strobe(sym_strobe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic push(input int x, input logic [1:0] s);
    exp_t e;
    e.x   = 18'(x);
    e.sym = s;
    q.push_back(e);
  endtask

  task automatic drain(input string tag, output int cycles);
    cycles = 0;
    while (q.size() != 0 && cycles < 100) begin
      @(negedge clk);
      #1;
      cycles++;
    end
    if (q.size() != 0) begin
      chk({tag, "_timeout"}, q.size(), 0);
      q.delete();
    end
  endtask

  // outputs are registered on posedge; sample on the falling edge
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (sym_strobe) begin
      if (q.size() == 0) begin
        chk("unexpected_strobe", 1, 0);
      end else begin
        e = q.pop_front();
        chk("x_out", x_out, e.x);
        chk("sym_out", {30'd0, sym_out}, {30'd0, e.sym});
      end
      if (last_sc >= 0) chk("strobe_period", cyc - last_sc, SPS);
      last_sc = cyc;
    end else begin
      chk("zero_between", x_out, 0);
    end
  end

  initial begin
    logic [1:0] fs[4];
    int         fl[4];
    fs = '{2'b01, 2'b11, 2'b10, 2'b00};
    fl = '{M1, P1, P3, M3};

    reset = 1'b0; enable = 1'b0; mode = 2'd0; sym_in = 2'd0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_x", x_out, 0);
    chk("rst_sym", {30'd0, sym_out}, 0);
    chk("rst_strobe", {31'd0, sym_strobe}, 0);

    // PRBS from SEED=1: seven -3a symbols then +3a
    for (int i = 0; i < 7; i++) push(M3, 2'b00);
    push(P3, 2'b10);
    reset = 1'b1; enable = 1'b1;
    drain("prbs", n);
    chk("prbs_cycles", n, 1 + 7 * SPS);

    // impulse fires once, later boundaries strobe zero
    mode = 2'd1;
    push(P3, 2'b10); push(0, 2'b00); push(0, 2'b00);
    drain("impulse", n);
    mode = 2'd2; sym_in = 2'b01;
    push(M1, 2'b01);
    drain("impulse_break", n);
    mode = 2'd1;
    push(P3, 2'b10); push(0, 2'b00);
    drain("impulse_refire", n);

    // fixed symbols on successive boundaries
    mode = 2'd2;
    for (int i = 0; i < 4; i++) begin
      sym_in = fs[i];
      push(fl[i], fs[i]);
      drain("fixed", n);
    end

    // worst-case alternation, then a 5-cycle enable gap
    mode = 2'd3;
    push(P3, 2'b10); push(M3, 2'b00); push(P3, 2'b10);
    drain("worst", n);
    enable = 1'b0;
    last_sc = -1;
    repeat (5) @(negedge clk);
    #1;
    push(M3, 2'b00);
    enable = 1'b1;
    drain("worst_resume", n);
    chk("resume_phase_held", n, SPS);

    // mode change at phase 1 waits for the boundary; leaving mode 3 resets the toggle
    mode = 2'd2; sym_in = 2'b01;
    push(M1, 2'b01);
    drain("midsym_mode", n);
    chk("midsym_latency", n, SPS);
    mode = 2'd3;
    push(P3, 2'b10);
    drain("toggle_reset", n);

    // async reset at phase 2, then PRBS restarts from SEED
    mode = 2'd0;
    @(posedge clk);
    #2;
    chk("sym_hold", {30'd0, sym_out}, 2);
    reset = 1'b0;
    #1;
    chk("areset_sym", {30'd0, sym_out}, 0);
    chk("areset_x", x_out, 0);
    chk("areset_strobe", {31'd0, sym_strobe}, 0);
    last_sc = -1;
    for (int i = 0; i < 7; i++) push(M3, 2'b00);
    push(P3, 2'b10);
    @(negedge clk);
    #1;
    reset = 1'b1;
    drain("prbs_reload", n);
    chk("reload_cycles", n, 1 + 7 * SPS);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ask4_symbol_src.md
# ask4_symbol_src

Upstream source for the TX_filt → RCV_filt cascade. Generates a 4-ASK (PAM-4) symbol stream in 1s17 format, upsampled by zero-insertion to the filter sample rate, so TX_filt receives a pulse-shaping impulse train. Replaces file-driven stimulus (PRBS, impulse, fixed-level, worst-case) with on-chip synthesisable generation.

## Interface
- SPS, default 4: samples per symbol (≥2); nonzero sample on phase 0 only.
- LEVEL_A, default 18'sd32768: inner level a (0.25 in 1s17); outer level is 3·LEVEL_A and must satisfy 3·LEVEL_A ≤ 131071.
- SEED, default 15'h0001: LFSR reset value; must be nonzero.
- clk  in  1  sample clock, rising edge.
- reset  in  1  asynchronous, active-low (asserted when 0).
- enable  in  1  advance phase counter/LFSR when high.
- mode  in  2  0 PRBS, 1 impulse, 2 fixed symbol, 3 worst-case alternating.
- sym_in  in  2  Gray symbol used in mode 2.
- x_out  out  18 signed 1s17 sample to TX_filt x_in.
- sym_out  out  2  Gray symbol of the most recent strobe.
- sym_strobe  out  1  high for the one cycle x_out carries a symbol.

## Operation
- Gray map: 00 → −3a, 01 → −a, 11 → +a, 10 → +3a (a = LEVEL_A).
- Phase counter 0..SPS−1; wraps SPS−1 → 0; advances only when enable=1.
- Edge with enable=1 and phase=0 (symbol boundary): sample mode, choose symbol, register x_out = level, sym_out = symbol, sym_strobe = 1.
- Edge with enable=1 and phase≠0: x_out ← 0, sym_strobe ← 0, sym_out holds.
- enable=0: phase, LFSR, alternation and impulse state hold; x_out ← 0, sym_strobe ← 0.
- Mode 0 PRBS: 15-bit Fibonacci LFSR, feedback f = l[14]^l[13], shift left, l[0] ← f. Output bit = l[14] before shift. Two shifts per symbol; first bit = sym MSB. LFSR steps only at boundaries in mode 0.
- Mode 1 impulse: first boundary after entering mode emits +3a (symbol 10); all later boundaries emit 0 with sym_strobe=1, sym_out=00. impulse_done flag set on firing; cleared by reset or any boundary with mode≠1.
- Mode 2: symbol = sym_in sampled at boundary.
- Mode 3: alternates +3a, −3a, +3a… starting +3a; toggle advances only at mode-3 boundaries; toggle reset to "+" on reset or any boundary with mode≠3.
- Mode changes between boundaries have no effect until next boundary.
- Arithmetic: 3a formed as (a<<1)+a in 19 bits, truncated to 18 (range guaranteed by parameter rule); negation two's complement.

## Timing
- Reset values: x_out=0, sym_out=00, sym_strobe=0, phase=0, LFSR=SEED, toggle="+", impulse_done=0.
- Reset asserted mid-symbol: all state returns to reset values immediately (async); first edge after release with enable=1 is a boundary.
- Latency: one register; x_out valid the cycle after the boundary edge, aligned with sym_strobe.
- Steady state enable=1: sym_strobe period exactly SPS cycles; SPS−1 zero samples between symbols.

## Structure
- Package ask4_pkg: mode enum (MODE_PRBS, MODE_IMPULSE, MODE_FIXED, MODE_WORST), Gray symbol constants, LFSR width/taps, function gray_to_level(sym, a) returning 18-bit signed.
- Sub-module lfsr_prbs15: clk, reset, step, 2-bit symbol output; holds SEED on reset, advances two bits per step.
- Top: phase counter, mode mux, impulse/alternation state, output register.

## Test plan
- Reset release, mode 0, SEED=1, SPS=4, enable=1 → strobes 1–7 x_out = −98304, strobe 8 x_out = +98304; zeros between; strobe every 4 cycles.
- Mode 1 → single sample +98304 at first strobe, all following samples 0; switch to mode 2 and back to 1 → impulse fires again.
- Mode 2, sym_in = 01, 11, 10, 00 on successive boundaries → −32768, +32768, +98304, −98304.
- Mode 3 → +98304, −98304, +98304 on consecutive strobes; enable low for 5 cycles mid-run → x_out=0, sequence resumes with next value, phase unchanged.
- Assert reset (0) at phase 2 → outputs 0 asynchronously, LFSR reloads SEED; after release PRBS repeats strobe-1 value −98304.
- mode changed at phase 1 → no output change until next phase-0 edge.
